// File: rtl/lam_mem_if.sv
// Data-memory port bundle between lam_unit and the memory.
// Request fields are held by the master until mem_ack.
interface lam_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lam_unit.sv
// Load/store access unit: one data-memory transaction per
// instruction, load results returned to the register file.
module lam_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lam_new,
  input  logic [8:0]  lam_control,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  lam_mem_if.master   mem,
  output logic        wb_en,
  output logic [4:0]  wb_sel,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        exc,
  output logic [1:0]  exc_cause
);

  typedef enum logic [1:0] {
    IDLE, REQ, RESP
  } state_t;

  localparam logic        TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [8:0]  ctl_q, ctl_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        exc_q, exc_d;
  logic [1:0]  cause_q, cause_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_sel_q, wb_sel_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic [2:0]  f3_in;
  logic        st_in, legal, misal;
  logic [3:0]  be_in;
  logic [31:0] wd_in;
  logic [31:0] sh;
  logic [31:0] ld_val;
  logic        sgn, req;

  assign f3_in = lam_control[7:5];
  assign st_in = lam_control[8];

  assign legal = st_in
    ? (!f3_in[2] && f3_in[1:0] != 2'b11)
    : (f3_in[1:0] != 2'b11 && !(f3_in[2] && f3_in[1]));

  assign misal =
    (f3_in[1:0] == 2'b01 && addr[0]) ||
    (f3_in[1:0] == 2'b10 && addr[1:0] != 2'b00);

  always_comb begin
    be_in = 4'b1111;
    wd_in = store_data;
    unique case (1'b1)
      (f3_in[1:0] == 2'b00): begin
        be_in = 4'b0001 << addr[1:0];
        wd_in = {4{store_data[7:0]}};
      end
      (f3_in[1:0] == 2'b01): begin
        be_in = addr[1] ? 4'b1100 : 4'b0011;
        wd_in = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Halves are aligned, so the byte shift also lands them at [15:0].
  assign sh  = mem.mem_rdata >> {addr_q[1:0], 3'b000};
  assign sgn = !ctl_q[7];

  always_comb begin
    ld_val = mem.mem_rdata;
    unique case (1'b1)
      (ctl_q[6:5] == 2'b00):
        ld_val = {{24{sgn & sh[7]}}, sh[7:0]};
      (ctl_q[6:5] == 2'b01):
        ld_val = {{16{sgn & sh[15]}}, sh[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ctl_d     = ctl_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    exc_d     = 1'b0;
    cause_d   = cause_q;
    wb_en_d   = 1'b0;
    wb_sel_d  = wb_sel_q;
    wb_data_d = wb_data_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (lam_new) begin
          ctl_d   = lam_control;
          addr_d  = addr;
          wdata_d = wd_in;
          be_d    = be_in;
          if (!legal) begin
            exc_d   = 1'b1;
            cause_d = 2'b10;
          end else if (misal) begin
            exc_d   = 1'b1;
            cause_d = 2'b01;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          done_d = 1'b1;
          if (ctl_q[8]) begin
            state_d = IDLE;
          end else begin
            state_d   = RESP;
            wb_en_d   = (ctl_q[4:0] != 5'd0);
            wb_sel_d  = ctl_q[4:0];
            wb_data_d = ld_val;
          end
        end else if (TO_EN && cnt_q == LIMIT) begin
          state_d = IDLE;
          exc_d   = 1'b1;
          cause_d = 2'b11;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ctl_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      exc_q     <= 1'b0;
      cause_q   <= '0;
      wb_en_q   <= 1'b0;
      wb_sel_q  <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ctl_q     <= ctl_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      exc_q     <= exc_d;
      cause_q   <= cause_d;
      wb_en_q   <= wb_en_d;
      wb_sel_q  <= wb_sel_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign req           = (state_q == REQ);
  assign busy          = (state_q != IDLE);
  assign mem.mem_req   = req;
  assign mem.mem_we    = req & ctl_q[8];
  assign mem.mem_addr  = req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem.mem_be    = req ? be_q : 4'd0;
  assign mem.mem_wdata = req ? wdata_q : 32'd0;
  assign done          = done_q;
  assign exc           = exc_q;
  assign exc_cause     = cause_q;
  assign wb_en         = wb_en_q;
  assign wb_sel        = wb_sel_q;
  assign wb_data       = wb_data_q;

endmodule

// File: tb/tb_lam_unit.sv
// Scoreboard bench for lam_unit: a byte-level memory model predicts
// requests and completions; monitors compare as the DUT presents them.
module tb_lam_unit;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lam_new = 1'b0;
  logic [8:0]  lam_control = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        busy, wb_en, done, exc;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data;
  logic [1:0]  exc_cause;

  lam_mem_if mif();

  lam_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .lam_new(lam_new),
    .lam_control(lam_control),
    .addr(addr),
    .store_data(store_data),
    .busy(busy),
    .mem(mif.master),
    .wb_en(wb_en),
    .wb_sel(wb_sel),
    .wb_data(wb_data),
    .done(done),
    .exc(exc),
    .exc_cause(exc_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [1:0]  cause;
    logic        wb;
    logic [4:0]  sel;
    logic [31:0] data;
    int          at;
  } ev_t;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
  } rq_t;

  ev_t ev_q[$];
  rq_t rq_q[$];
  ev_t me;
  rq_t mr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ack_delay = 0;
  int rc = 0;
  int last_run = 0;
  int ack_cyc = 0;
  bit no_ack = 1'b0;
  logic [31:0] rdata_v = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Memory responder: checks request fields, acks after ack_delay.
  always @(negedge clk) begin
    if (!rst_n) begin
      rc = 0;
      mif.mem_ack = 1'b0;
      mif.mem_rdata = '0;
    end else if (mif.mem_req) begin
      if (rc == 0) begin
        if (rq_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_mem_req: got addr %h expected none",
                   mif.mem_addr);
        end else begin
          mr = rq_q.pop_front();
          chk("mem_we", 32'(mif.mem_we), 32'(mr.we));
          chk("mem_addr", mif.mem_addr, mr.a);
          chk("mem_be", 32'(mif.mem_be), 32'(mr.be));
          if (mr.we) chk("mem_wdata", mif.mem_wdata, mr.wd);
        end
      end
      if (!no_ack && rc == ack_delay) begin
        mif.mem_ack = 1'b1;
        mif.mem_rdata = rdata_v;
        ack_cyc = cyc;
      end else begin
        mif.mem_ack = 1'b0;
        mif.mem_rdata = $urandom;
      end
      rc++;
    end else begin
      if (rc != 0) last_run = rc;
      rc = 0;
      mif.mem_ack = 1'b0;
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (rst_n && (done || exc || wb_en)) begin
      if (ev_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got done=%b exc=%b wb_en=%b expected none",
                 done, exc, wb_en);
      end else begin
        me = ev_q.pop_front();
        chk("done", 32'(done), 32'(me.kind != 2));
        chk("exc", 32'(exc), 32'(me.kind == 2));
        if (me.kind == 2) chk("exc_cause", 32'(exc_cause), 32'(me.cause));
        chk("wb_en", 32'(wb_en), 32'(me.wb));
        if (me.wb) begin
          chk("wb_sel", 32'(wb_sel), 32'(me.sel));
          chk("wb_data", wb_data, me.data);
        end
        chk("event_cycle", 32'(cyc),
            32'(me.at < 0 ? ack_cyc + 1 : me.at));
      end
    end
  end

  task automatic issue(input bit st, input bit [2:0] f3,
                       input bit [4:0] rd, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rdv,
                       input int dly, input bit nack);
    ev_t e;
    rq_t r;
    int sz, k, n;
    bit leg, mis;
    longint v;
    sz = 1 << f3[1:0];
    k = int'(a[1:0]);
    leg = st ? (f3 <= 3'd2)
             : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = leg && ((k % sz) != 0);
    ack_delay = dly;
    no_ack = nack;
    rdata_v = rdv;
    last_run = 0;
    @(posedge clk);
    #1;
    lam_new = 1'b1;
    lam_control = {st, f3, rd};
    addr = a;
    store_data = d;
    e.kind = 0;
    e.cause = 2'd0;
    e.wb = 1'b0;
    e.sel = 5'd0;
    e.data = '0;
    e.at = -1;
    if (!leg) begin
      e.kind = 2;
      e.cause = 2'd2;
      e.at = cyc + 1;
    end else if (mis) begin
      e.kind = 2;
      e.cause = 2'd1;
      e.at = cyc + 1;
    end else begin
      r.we = st;
      r.a = a & 32'hFFFF_FFFC;
      r.be = 4'(((1 << sz) - 1) << k);
      for (int i = 0; i < 4; i++) r.wd[8*i +: 8] = d[8*(i % sz) +: 8];
      rq_q.push_back(r);
      if (nack) begin
        e.kind = 2;
        e.cause = 2'd3;
        e.at = cyc + 1 + TO;
      end else if (!st) begin
        e.kind = 1;
        v = 0;
        for (int i = 0; i < sz; i++)
          v = v | (longint'(rdv[8*(k+i) +: 8]) << (8*i));
        if (!f3[2] && sz < 4 && v[8*sz-1])
          v = v - (longint'(1) << (8*sz));
        e.data = v[31:0];
        e.wb = (rd != 5'd0);
        e.sel = rd;
      end
    end
    ev_q.push_back(e);
    @(posedge clk);
    #1;
    lam_new = 1'b0;
    lam_control = 9'($urandom);
    addr = $urandom;
    store_data = $urandom;
    n = 0;
    while (ev_q.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (ev_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL completion_timeout: got %0d pending expected 0",
               ev_q.size());
      ev_q.delete();
      rq_q.delete();
    end
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);
    if (nack && leg && !mis) chk("req_cycles", 32'(last_run), 32'(TO));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mif.mem_req), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_exc", 32'(exc), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    #3 rst_n = 1'b1;

    issue(1, 3'd2, 5'd7, 32'h100, 32'hDEADBEEF, 0, 2, 0);
    issue(1, 3'd0, 5'd7, 32'h203, 32'h000000A5, 0, 1, 0);
    issue(1, 3'd1, 5'd3, 32'h306, 32'h1234ABCD, 0, 0, 0);
    issue(0, 3'd0, 5'd5, 32'h103, 0, 32'h80112233, 1, 0);
    issue(0, 3'd4, 5'd5, 32'h103, 0, 32'h80112233, 0, 0);
    issue(0, 3'd1, 5'd5, 32'h102, 0, 32'h80112233, 2, 0);
    issue(0, 3'd5, 5'd5, 32'h102, 0, 32'h80112233, 3, 0);
    issue(0, 3'd2, 5'd9, 32'h102, 0, 32'h0, 0, 0);
    issue(0, 3'd3, 5'd9, 32'h100, 0, 32'h0, 0, 0);
    issue(0, 3'd3, 5'd9, 32'h101, 0, 32'h0, 0, 0);
    issue(1, 3'd4, 5'd9, 32'h100, 0, 32'h0, 0, 0);
    issue(0, 3'd2, 5'd4, 32'h40, 0, 32'h0, 0, 1);
    issue(0, 3'd2, 5'd4, 32'h40, 0, 32'hCAFEF00D, TO - 1, 0);
    issue(0, 3'd2, 5'd0, 32'h44, 0, 32'h55AA55AA, 1, 0);

    // Reset in the middle of an outstanding load.
    rq_q.push_back('{we: 1'b0, a: 32'h80, be: 4'hF, wd: 32'h0});
    no_ack = 1'b1;
    @(posedge clk);
    #1;
    lam_new = 1'b1;
    lam_control = {1'b0, 3'd2, 5'd3};
    addr = 32'h80;
    @(posedge clk);
    #1;
    lam_new = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_req", 32'(mif.mem_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    ev_q.delete();
    rq_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    issue(0, 3'd2, 5'd12, 32'h84, 0, 32'h01020304, 1, 0);

    for (int i = 0; i < 60; i++) begin
      bit s;
      s = 1'($urandom_range(0, 1));
      issue(s, 3'(s ? $urandom_range(0, 3) : $urandom_range(0, 6)),
            5'($urandom), $urandom, $urandom, $urandom,
            int'($urandom_range(0, 3)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/lam_unit.md
Name: lam_unit

Overview:
- Load/store access unit: consumes the decoder's LAM control word and strobe, performs one data-memory transaction per instruction, and returns load results to the register file.
- Sits between the decoder/ALU (effective address, store operand) and the data-memory port.
- Stalls the core via `busy` while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles mem_req may wait for mem_ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- lam_new  in  1  one-cycle strobe qualifying lam_control; asserted for both loads and stores
- lam_control  in  9  {is_store[8], funct3[7:5], reg_idx[4:0]}; reg_idx is rd for loads, rs2 for stores (informational)
- addr  in  32  effective address (rs1+imm from ALU), valid with lam_new
- store_data  in  32  rs2 value, valid with lam_new
- busy  out  1  transaction in progress; upstream holds the instruction while high
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  memory completes the request this cycle
- mem_rdata  in  32  read data, valid with mem_ack
- wb_en  out  1  one-cycle register write strobe (loads only)
- wb_sel  out  5  destination register
- wb_data  out  32  extended load result
- done  out  1  one-cycle completion pulse (loads and stores)
- exc  out  1  one-cycle exception pulse
- exc_cause  out  2  01 misaligned, 10 illegal funct3, 11 bus timeout; valid with exc

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output and all internal registers 0, effective immediately. An in-flight request is dropped with no ack wait.
- States: IDLE, REQ, RESP.
- busy = (state != IDLE).
- Accept: in IDLE, lam_new=1 registers control, addr and data (cycle T).
  - Checks are performed at accept, before any state change:
    - funct3 legal: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
    - Alignment: H requires addr[0]=0; W requires addr[1:0]=0.
  - Illegal funct3 → exc=1, cause 10 at T+1; stay IDLE; no mem_req.
  - Misaligned → exc=1, cause 01 at T+1; stay IDLE; no mem_req.
  - If both fail, cause 10 takes priority.
  - Otherwise → REQ.
- lam_new while busy is ignored; upstream must not present a new instruction.
- REQ:
  - mem_req=1 from T+1, registered.
  - mem_we, mem_addr, mem_be, mem_wdata are stable until the ack cycle.
  - mem_ack is sampled in the same cycle as mem_req; earliest ack is T+1.
- Store lanes, k=addr[1:0]:
  - SB: be=1<<k, wdata={4{data[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{data[15:0]}}.
  - SW: be=1111, wdata=data.
- Loads: mem_we=0, mem_be per size as for stores (informational).
- Ack on a store → IDLE; done=1 next cycle; mem_req drops the cycle after ack.
- Ack on a load → mem_rdata captured, RESP. Extraction:
  - LB/LBU: byte k, sign-/zero-extended.
  - LH/LHU: half addr[1], sign-/zero-extended.
  - LW: the full word.
- RESP (one cycle): done=1; wb_sel=rd; wb_data=result; wb_en=1 unless rd==0 (x0 never written); → IDLE. Load latency is ack+1.
- Timeout:
  - A counter starts at 0 on REQ entry and increments each REQ cycle without ack.
  - If it reaches TIMEOUT_CYCLES: mem_req drops next cycle, exc=1, cause 11, → IDLE, no wb/done.
  - An ack in the same cycle the limit is hit wins (normal completion).
- wb_data/wb_sel hold their last values when wb_en=0; mem_* outputs are 0 in IDLE.

Test Plan:
1. SW addr 0x100, data 0xDEADBEEF, ack 2 cycles after req → mem_addr 0x100, be 1111, wdata 0xDEADBEEF, we=1; done pulse ack+1; wb_en never high.
2. SB addr 0x203, data 0x000000A5 → mem_addr 0x200, be 1000, wdata 0xA5A5A5A5; busy low after done.
3. LB rd=5 addr 0x103, rdata 0x80112233 → wb_en, wb_sel 5, wb_data 0xFFFFFF80. LBU same → 0x00000080. LH addr 0x102 → 0xFFFF8011. LHU → 0x00008011.
4. LW addr 0x102 → exc, cause 01 at T+1; mem_req never asserted. Funct3 011 load → cause 10.
5. LW addr 0x40, no ack, TIMEOUT_CYCLES=16 → mem_req high exactly 16 cycles, then exc cause 11; busy clears. Repeat with ack on the 16th cycle → normal wb.
6. LW rd=0 with ack → done=1, wb_en=0. Then rst_n low mid-REQ → mem_req, busy, done all 0 immediately; the next lam_new is accepted normally after release.
